// File: rtl/pipelined_add_sub.sv
// rtl/pipelined_add_sub.sv - pipelined chunked-carry adder/subtractor with valid/ready handshake
module pipelined_add_sub #(
    parameter int N      = 32,
    parameter int STAGES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         ovf
);

    localparam int CHUNK = N / STAGES;
    localparam int LAST  = STAGES - 1;

    // Per-stage registers: operands travel with the beat, sum chunks fill in as they resolve.
    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] c_q;
    logic [N-1:0]      a_q [STAGES];
    logic [N-1:0]      b_q [STAGES];
    logic [N-1:0]      s_q [STAGES];
    logic              ovf_q;

    logic [STAGES-1:0] v_i;
    logic [STAGES-1:0] c_i;
    logic [STAGES-1:0] c_n;
    logic [N-1:0]      a_i [STAGES];
    logic [N-1:0]      b_i [STAGES];
    logic [N-1:0]      s_i [STAGES];
    logic [N-1:0]      s_n [STAGES];
    logic [CHUNK:0]    part;
    logic              ovf_n;

    always_comb begin
        v_i  = '0;
        c_i  = '0;
        c_n  = '0;
        part = '0;
        for (int k = 0; k < STAGES; k++) begin
            a_i[k] = '0;
            b_i[k] = '0;
            s_i[k] = '0;
            s_n[k] = '0;
        end

        // Stage 0 sees the incoming beat; subtraction folds into a + ~b + 1.
        a_i[0] = a;
        b_i[0] = sub ? ~b : b;
        c_i[0] = sub | cin;
        v_i[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            a_i[k] = a_q[k-1];
            b_i[k] = b_q[k-1];
            s_i[k] = s_q[k-1];
            c_i[k] = c_q[k-1];
            v_i[k] = v_q[k-1];
        end

        for (int k = 0; k < STAGES; k++) begin
            part = {1'b0, a_i[k][k*CHUNK +: CHUNK]} + {1'b0, b_i[k][k*CHUNK +: CHUNK]}
                 + {{CHUNK{1'b0}}, c_i[k]};
            s_n[k] = s_i[k];
            s_n[k][k*CHUNK +: CHUNK] = part[CHUNK-1:0];
            c_n[k] = part[CHUNK];
        end

        ovf_n = (a_i[LAST][N-1] == b_i[LAST][N-1]) && (s_n[LAST][N-1] != a_i[LAST][N-1]);
    end

    // Bubbles advance valid bits only, so data registers keep their last real beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q   <= '0;
            c_q   <= '0;
            ovf_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else if (in_ready) begin
            v_q <= v_i;
            for (int k = 0; k < STAGES; k++) begin
                if (v_i[k]) begin
                    a_q[k] <= a_i[k];
                    b_q[k] <= b_i[k];
                    s_q[k] <= s_n[k];
                    c_q[k] <= c_n[k];
                end
            end
            if (v_i[LAST]) begin
                ovf_q <= ovf_n;
            end
        end
    end

    assign in_ready  = !v_q[LAST] || out_ready;
    assign out_valid = v_q[LAST];
    assign sum       = s_q[LAST];
    assign cout      = c_q[LAST];
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_add_sub.sv
// tb/tb_pipelined_add_sub.sv - directed and scoreboarded bench for pipelined_add_sub at N=8, STAGES=2
module tb_pipelined_add_sub;

    localparam int N      = 8;
    localparam int STAGES = 2;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         in_ready;
    logic [N-1:0] a         = '0;
    logic [N-1:0] b         = '0;
    logic         cin       = 1'b0;
    logic         sub       = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [N-1:0] sum;
    logic         cout;
    logic         ovf;

    int vectors     = 0;
    int miscompares = 0;
    int n_out       = 0;
    bit sb_on       = 1'b0;
    logic [9:0] exp_q[$];

    always #5 clk = ~clk;

    pipelined_add_sub #(.N(N), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference built from integer arithmetic: returns {ovf, cout, sum}.
    function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y,
                                         input logic ci, input logic s);
        int sa, sb, r;
        logic [8:0] u;
        sa = $signed(x);
        sb = $signed(y);
        if (s) begin
            r = sa - sb;
            u = {1'b0, x} - {1'b0, y};
            return {(r < -128 || r > 127), (x >= y), u[7:0]};
        end
        r = sa + sb + int'(ci);
        u = {1'b0, x} + {1'b0, y} + {8'd0, ci};
        return {(r < -128 || r > 127), u[8], u[7:0]};
    endfunction

    task automatic one(input string tag, input logic [7:0] x, input logic [7:0] y,
                       input logic ci, input logic s, input logic [9:0] exp);
        in_valid  = 1'b1;
        a         = x;
        b         = y;
        cin       = ci;
        sub       = s;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk({tag, "_lat"}, 32'(out_valid), 32'd0);
        tick();
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk(tag, 32'({ovf, cout, sum}), 32'(exp));
    endtask

    always @(negedge clk) begin
        if (sb_on) begin
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b, cin, sub));
            end
            if (out_valid && out_ready) begin
                n_out++;
                chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    chk("sb_data", 32'({ovf, cout, sum}), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #2;
        chk("reset_valid", 32'(out_valid), 32'd0);
        chk("reset_data", 32'({ovf, cout, sum}), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Directed carry / overflow / subtract vectors
        one("add_ff_01",  8'hFF, 8'h01, 1'b0, 1'b0, 10'h100);
        one("add_7f_cin", 8'h7F, 8'h00, 1'b1, 1'b0, 10'h280);
        one("add_80_80",  8'h80, 8'h80, 1'b0, 1'b0, 10'h300);
        one("sub_05_07",  8'h05, 8'h07, 1'b0, 1'b1, 10'h0FE);
        one("sub_80_01",  8'h80, 8'h01, 1'b0, 1'b1, 10'h37F);
        one("sub_cin_ign", 8'h10, 8'h10, 1'b1, 1'b1, 10'h100);
        one("sub_7f_ff",  8'h7F, 8'hFF, 1'b0, 1'b1, 10'h280);

        out_ready = 1'b1;
        tick();
        chk("drained", 32'(out_valid), 32'd0);
        chk("hold_after_drain", 32'({ovf, cout, sum}), 32'h280);

        // Back-pressure with a full pipeline
        out_ready = 1'b0;
        in_valid  = 1'b1;
        sub       = 1'b0;
        cin       = 1'b0;
        a = 8'h10; b = 8'h20;
        tick();
        a = 8'h40; b = 8'h50;
        tick();
        a = 8'hF0; b = 8'h20;
        for (int i = 0; i < 5; i++) begin
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_data", 32'({ovf, cout, sum}), 32'h030);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("resume_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("resume_x1", 32'({ovf, cout, sum}), 32'h290);
        tick();
        chk("resume_x2_valid", 32'(out_valid), 32'd1);
        chk("resume_x2", 32'({ovf, cout, sum}), 32'h110);
        tick();
        chk("resume_empty", 32'(out_valid), 32'd0);

        // Random traffic with random back-pressure
        sb_on = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            a         = 8'($urandom);
            b         = 8'($urandom);
            cin       = 1'($urandom_range(0, 1));
            sub       = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        chk("random_drain", 32'(exp_q.size()), 32'd0);

        // Full throughput: one result per cycle
        n_out = 0;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            a        = 8'($urandom);
            b        = 8'($urandom);
            cin      = 1'($urandom_range(0, 1));
            sub      = 1'($urandom_range(0, 1));
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        chk("throughput", 32'(n_out), 32'd20);
        chk("throughput_drain", 32'(exp_q.size()), 32'd0);
        sb_on = 1'b0;

        // Asynchronous reset with two beats in flight
        out_ready = 1'b1;
        in_valid  = 1'b1;
        sub = 1'b0; cin = 1'b0;
        a = 8'h7F; b = 8'h01;
        tick();
        a = 8'h01; b = 8'h01;
        tick();
        in_valid = 1'b0;
        chk("rst_pre_valid", 32'(out_valid), 32'd1);
        chk("rst_pre_data", 32'({ovf, cout, sum}), 32'h280);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_valid", 32'(out_valid), 32'd0);
        chk("rst_async_data", 32'({ovf, cout, sum}), 32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rst_no_stale", 32'(out_valid), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
